// File: rtl/pipo_load_arbiter.sv
// Four-way arbiter that shares one pipo register: a single-cycle load per winner, then a HOLD-cycle ownership window.
// Build option: define PIPO_ARB_FIXED_PRIO_EN for fixed priority (requester 0 highest) instead of round-robin.
module pipo_load_arbiter #(
  parameter int WIDTH = 4,
  parameter int HOLD  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [3:0]       req,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  input  logic [WIDTH-1:0] din2,
  input  logic [WIDTH-1:0] din3,
  output logic             load,
  output logic [WIDTH-1:0] pi,
  output logic [3:0]       gnt,
  output logic [1:0]       owner,
  output logic             busy
);

  localparam int CW = (HOLD > 0) ? $clog2(HOLD + 1) : 1;
  localparam logic [CW-1:0] HOLD_LAST = (HOLD > 0) ? CW'(HOLD - 1) : '0;

  typedef enum logic [1:0] {ST_IDLE, ST_GRANT, ST_HOLD} state_t;

  state_t          state, state_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic            load_n, busy_n;
  logic [3:0]      gnt_n;
  logic [WIDTH-1:0] pi_n, din_sel;
  logic [1:0]      owner_n, win, idx, base;

`ifdef PIPO_ARB_FIXED_PRIO_EN
  assign base = 2'd0;
`else
  logic [1:0] ptr, ptr_n;
  assign base = ptr;
`endif

  // Scan downward so the requester closest above the search base is the last to overwrite win.
  always_comb begin
    win = base;
    idx = base;
    for (int k = 3; k >= 0; k--) begin
      idx = base + 2'(k);
      if (req[idx]) win = idx;
    end
  end

  always_comb begin
    case (win)
      2'd0:    din_sel = din0;
      2'd1:    din_sel = din1;
      2'd2:    din_sel = din2;
      default: din_sel = din3;
    endcase
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    load_n  = 1'b0;
    gnt_n   = 4'b0000;
    pi_n    = pi;
    owner_n = owner;
    busy_n  = busy;
`ifndef PIPO_ARB_FIXED_PRIO_EN
    ptr_n   = ptr;
`endif
    case (state)
      ST_IDLE: begin
        if (req != 4'b0000) begin
          state_n = ST_GRANT;
          load_n  = 1'b1;
          gnt_n   = 4'b0001 << win;
          pi_n    = din_sel;
          owner_n = win;
          busy_n  = 1'b1;
`ifndef PIPO_ARB_FIXED_PRIO_EN
          ptr_n   = win + 2'd1;
`endif
        end
      end
      ST_GRANT: begin
        if (HOLD > 0) begin
          state_n = ST_HOLD;
          cnt_n   = HOLD_LAST;
        end else begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
        end
      end
      ST_HOLD: begin
        if (cnt == '0) begin
          state_n = ST_IDLE;
          busy_n  = 1'b0;
        end else begin
          cnt_n = cnt - CW'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // Every output is a flop; reset abandons any hold in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
      load  <= 1'b0;
      gnt   <= 4'b0000;
      pi    <= '0;
      owner <= 2'd0;
      busy  <= 1'b0;
`ifndef PIPO_ARB_FIXED_PRIO_EN
      ptr   <= 2'd0;
`endif
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      load  <= load_n;
      gnt   <= gnt_n;
      pi    <= pi_n;
      owner <= owner_n;
      busy  <= busy_n;
`ifndef PIPO_ARB_FIXED_PRIO_EN
      ptr   <= ptr_n;
`endif
    end
  end

endmodule
